// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter:
// output-slot state encoding and default sizing constants.
package adder_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDW   = 2;
    localparam int DEF_CNTW  = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: rotate requests so that the
// pointer position comes first, take the lowest set bit, rotate back.
// Ports:
//   i_req    requests, one bit per requester
//   i_ptr    requester with highest priority this cycle
//   o_gnt    one-hot grant (zero when no request)
//   o_gnt_id index of the granted requester
//   o_any    at least one request present
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_pick;

    // (base + off) mod NREQ; off never exceeds NREQ-1 here
    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] base,
        input logic [IDW:0]   off
    );
        logic [IDW:0] s;
        s = {1'b0, base} + off;
        if (s >= (IDW+1)'(NREQ)) begin
            s = s - (IDW+1)'(NREQ);
        end
        return s[IDW-1:0];
    endfunction

    always_comb begin
        w_rot = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_rot[j] = i_req[wrap_add(i_ptr, (IDW+1)'(j))];
        end
    end

    // Scan downwards so the lowest rotated position wins
    always_comb begin
        w_pick = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_pick = IDW'(j);
            end
        end
    end

    always_comb begin
        o_any    = |w_rot;
        o_gnt_id = wrap_add(i_ptr, {1'b0, w_pick});
        o_gnt    = '0;
        if (o_any) begin
            o_gnt[o_gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// One registered WIDTH-bit adder shared by NREQ requesters under
// round-robin arbitration, with a single-entry result slot.
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_req_valid/o_req_ready per-requester handshake (ready is one-hot)
//   i_req_a, i_req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   i_req_cin              carry-in per requester
//   o_rsp_valid/i_rsp_ready result handshake
//   o_rsp_sum, o_rsp_id    {carry, sum} and owning requester
//   o_grant_cnt            saturating count of grants since reset
//   o_busy                 result pending or any request present
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]       i_req_cin,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [WIDTH:0]        o_rsp_sum,
    output logic [IDW-1:0]        o_rsp_id,
    output logic [CNTW-1:0]       o_grant_cnt,
    output logic                  o_busy
);

    slot_state_t r_state;
    slot_state_t w_state_nxt;

    logic [IDW-1:0]  r_ptr;
    logic [WIDTH:0]  r_sum;
    logic [IDW-1:0]  r_id;
    logic [CNTW-1:0] r_cnt;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_any;
    logic            w_slot_free;
    logic            w_grant;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic            w_cin;
    logic [WIDTH:0]  w_sum;
    logic [IDW-1:0]  w_ptr_nxt;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    // A full slot frees up in the same cycle it is popped
    assign w_slot_free = (r_state == ST_EMPTY) | i_rsp_ready;
    assign w_grant     = i_rst_n & w_slot_free & w_any;
    assign o_req_ready = w_grant ? w_gnt : '0;

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_a   = i_req_a[i*WIDTH +: WIDTH];
                w_b   = i_req_b[i*WIDTH +: WIDTH];
                w_cin = i_req_cin[i];
            end
        end
    end

    // Zero-extend so the carry lands in bit WIDTH
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

    assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0
                                                    : w_gnt_id + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if (i_rsp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_sum <= '0;
            r_id  <= '0;
            r_cnt <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_nxt;
            r_sum <= w_sum;
            r_id  <= w_gnt_id;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rsp_valid = (r_state == ST_FULL);
    assign o_rsp_sum   = r_sum;
    assign o_rsp_id    = r_id;
    assign o_grant_cnt = r_cnt;
    assign o_busy      = o_rsp_valid | (|i_req_valid);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed vector table,
// randomized run against a reference model, counter saturation.
module tb_adder_rr_arbiter;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        rr;
        logic [3:0]  er;
        logic        erv;
        logic [32:0] es;
        logic [1:0]  eid;
        logic [15:0] ec;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] opa [4];
    logic [31:0] opb [4];
    logic [3:0]  cin;
    logic        rsp_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [32:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic [15:0] grant_cnt;
    logic        busy;

    logic        s_rst_n;
    logic [3:0]  s_valid;
    logic [127:0] s_a;
    logic [127:0] s_b;
    logic [3:0]  s_cin;
    logic        s_rsp_ready;
    logic [3:0]  s_ready;
    logic        s_rv;
    logic [32:0] s_sum;
    logic [1:0]  s_id;
    logic [3:0]  s_cnt;
    logic        s_busy;

    int n_vec = 0;
    int n_bad = 0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = opa[i];
            req_b[i*32 +: 32] = opb[i];
        end
    end

    adder_rr_arbiter #(
        .WIDTH (32), .NREQ (4), .IDW (2), .CNTW (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_cin   (cin),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_id    (rsp_id),
        .o_grant_cnt (grant_cnt),
        .o_busy      (busy)
    );

    adder_rr_arbiter #(
        .WIDTH (32), .NREQ (4), .IDW (2), .CNTW (4)
    ) u_sat (
        .i_clk       (clk),
        .i_rst_n     (s_rst_n),
        .i_req_valid (s_valid),
        .o_req_ready (s_ready),
        .i_req_a     (s_a),
        .i_req_b     (s_b),
        .i_req_cin   (s_cin),
        .o_rsp_valid (s_rv),
        .i_rsp_ready (s_rsp_ready),
        .o_rsp_sum   (s_sum),
        .o_rsp_id    (s_id),
        .o_grant_cnt (s_cnt),
        .o_busy      (s_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic rst_n_i, input logic [3:0] v,
        input logic [31:0] a, input logic [31:0] b, input logic c,
        input logic rr, input logic [3:0] er, input logic erv,
        input logic [32:0] es, input logic [1:0] eid,
        input logic [15:0] ec);
        vec_t t;
        t.rst_n = rst_n_i; t.valid = v; t.a = a; t.b = b; t.cin = c;
        t.rr = rr; t.er = er; t.erv = erv; t.es = es; t.eid = eid;
        t.ec = ec;
        return t;
    endfunction

    vec_t tv [22];
    logic [31:0] ops [10];

    // reference model state
    bit          m_valid;
    logic [32:0] m_sum;
    int          m_id;
    int          m_ptr;
    int          m_cnt;
    logic [32:0] sb [4];

    initial begin
        int g;
        int lg;
        logic [3:0] er;
        bit free;
        logic [63:0] ssum;

        rst_n = 1'b0; valid = '0; cin = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = '0; opb[i] = '0;
        end
        s_rst_n = 1'b0; s_valid = 4'b0010; s_cin = '0;
        s_rsp_ready = 1'b1; s_a = '0; s_b = '0;
        s_a[32 +: 32] = 32'd3;
        s_b[32 +: 32] = 32'd4;

        //            rst  valid    a             b             c  rr  er       rv  sum             id  cnt
        tv[0]  = mkv(0, 4'b1111, 32'd0,        32'd0,        0, 1, 4'b0000, 0, 33'd0,          0, 0);
        tv[1]  = mkv(0, 4'b1111, 32'd0,        32'd0,        0, 1, 4'b0000, 0, 33'd0,          0, 0);
        tv[2]  = mkv(1, 4'b0100, 32'd5,        32'd7,        1, 1, 4'b0100, 1, 33'd13,         2, 1);
        tv[3]  = mkv(1, 4'b0000, 32'd5,        32'd7,        1, 1, 4'b0000, 0, 33'd13,         2, 1);
        tv[4]  = mkv(0, 4'b0000, 32'd0,        32'd0,        0, 1, 4'b0000, 0, 33'd0,          0, 0);
        tv[5]  = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b0001, 1, 33'd30,         0, 1);
        tv[6]  = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b0010, 1, 33'd30,         1, 2);
        tv[7]  = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b0100, 1, 33'd30,         2, 3);
        tv[8]  = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b1000, 1, 33'd30,         3, 4);
        tv[9]  = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b0001, 1, 33'd30,         0, 5);
        tv[10] = mkv(1, 4'b1111, 32'd10,       32'd20,       0, 1, 4'b0010, 1, 33'd30,         1, 6);
        tv[11] = mkv(1, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 4'b0100, 1, 33'h1_FFFFFFFF, 2, 7);
        tv[12] = mkv(1, 4'b1111, 32'd0,        32'd0,        0, 1, 4'b1000, 1, 33'd0,          3, 8);
        for (int k = 13; k < 18; k++) begin
            tv[k] = mkv(1, 4'b0011, 32'd1, 32'd2, 0, 0, 4'b0000, 1, 33'd0, 3, 8);
        end
        tv[18] = mkv(1, 4'b0011, 32'd1,        32'd2,        0, 1, 4'b0001, 1, 33'd3,          0, 9);
        tv[19] = mkv(1, 4'b0011, 32'd1,        32'd2,        0, 0, 4'b0000, 1, 33'd3,          0, 9);
        tv[20] = mkv(0, 4'b0011, 32'd1,        32'd2,        0, 0, 4'b0000, 0, 33'd0,          0, 0);
        tv[21] = mkv(1, 4'b1001, 32'd4,        32'd4,        1, 1, 4'b0001, 1, 33'd9,          0, 1);

        for (int k = 0; k < 22; k++) begin
            rst_n = tv[k].rst_n;
            valid = tv[k].valid;
            rsp_ready = tv[k].rr;
            for (int i = 0; i < 4; i++) begin
                opa[i] = tv[k].a; opb[i] = tv[k].b;
            end
            cin = {4{tv[k].cin}};
            #2;
            chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tv[k].er));
            @(posedge clk); #1;
            chk($sformatf("v%0d_rvalid", k), 64'(rsp_valid), 64'(tv[k].erv));
            chk($sformatf("v%0d_sum", k), 64'(rsp_sum), 64'(tv[k].es));
            chk($sformatf("v%0d_id", k), 64'(rsp_id), 64'(tv[k].eid));
            chk($sformatf("v%0d_cnt", k), 64'(grant_cnt), 64'(tv[k].ec));
        end

        // randomized run against the reference model
        void'($urandom(32'd20240611));
        for (int i = 0; i < 10; i++) ops[i] = $urandom;
        ops[0] = 32'hFFFFFFFF;
        rst_n = 1'b0; valid = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_valid = 0; m_sum = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) sb[i] = '0;
        lg = -1;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!valid[i] || lg == i) begin
                    if ($urandom_range(0, 9) < 6) begin
                        valid[i] = 1'b1;
                        opa[i] = ops[$urandom_range(0, 9)];
                        opb[i] = ops[$urandom_range(0, 9)];
                        cin[i] = 1'($urandom_range(0, 1));
                    end else begin
                        valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #2;
            free = !m_valid || rsp_ready;
            g = -1;
            if (free) begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && valid[idx]) g = idx;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("rnd_ready", 64'(req_ready), 64'(er));
            chk("rnd_busy", 64'(busy), 64'(m_valid || (valid != 0)));
            if (m_valid && rsp_ready) begin
                chk("sb_pop", 64'(rsp_sum), 64'(sb[rsp_id]));
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                ssum = longint'(opa[g]) + longint'(opb[g]) + longint'(cin[g]);
                m_valid = 1;
                m_sum = ssum[32:0];
                sb[g] = ssum[32:0];
                m_id = g;
                m_ptr = (g + 1) % 4;
                if (m_cnt < 65535) m_cnt++;
            end else if (free) begin
                m_valid = 0;
            end
            lg = g;
            chk("rnd_rvalid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rnd_sum", 64'(rsp_sum), 64'(m_sum));
                chk("rnd_id", 64'(rsp_id), 64'(m_id));
            end
            chk("rnd_cnt", 64'(grant_cnt), 64'(m_cnt));
        end

        // lone requester on a 4-bit counter: saturates at 15, no wrap
        s_rst_n = 1'b1;
        #2;
        chk("sat_ready", 64'(s_ready), 64'(4'b0010));
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_cnt%0d", c), 64'(s_cnt),
                64'((c < 15) ? c : 15));
        end
        chk("sat_rvalid", 64'(s_rv), 64'(1));
        chk("sat_sum", 64'(s_sum), 64'(7));
        chk("sat_id", 64'(s_id), 64'(1));
        chk("sat_busy", 64'(s_busy), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
